// File: rtl/philo_pkg.sv
// Shared types and ring-index helpers for the dining-philosophers waiter.
// Optional starvation monitor is enabled with PHILO_STARVE_MON_EN.
package philo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    EATING  = 2'd2
  } seat_state_t;

  function automatic int unsigned left_of(int unsigned i, int unsigned n);
    return (i == 0) ? n - 1 : i - 1;
  endfunction

  function automatic int unsigned right_of(int unsigned i, int unsigned n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/philo_seat.sv
// Per-seat IDLE/WAITING/EATING state machine with optional wait-age counter.
// The age counter exists only when PHILO_STARVE_MON_EN is defined.
module philo_seat
  import philo_pkg::*;
#(
  parameter int unsigned AGE_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        done,
  input  logic        sel,
  output seat_state_t state,
  output logic        starve
);

  seat_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Withdrawal wins over selection; req while eating and done while not eating are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = WAITING;
      end
      WAITING: begin
        if (!req) begin
          state_d = IDLE;
        end else if (sel) begin
          state_d = EATING;
        end
      end
      EATING: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PHILO_STARVE_MON_EN
  localparam logic [AGE_W-1:0] AgeMax = '1;

  logic [AGE_W-1:0] age_q, age_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  // Age only survives while the seat stays in WAITING; it saturates at AgeMax.
  always_comb begin
    age_d = '0;
    if (state_q == WAITING && state_d == WAITING) begin
      age_d = (age_q == AgeMax) ? age_q : age_q + AGE_W'(1);
    end
  end

  always_comb begin
    state  = state_q;
    starve = (age_q == AgeMax);
  end
`else
  logic [AGE_W-1:0] unused_age;
  assign unused_age = '0;

  always_comb begin
    state  = state_q;
    starve = 1'b0;
  end
`endif

endmodule

// File: rtl/philo_waiter.sv
// Round-robin fork arbiter for an N-seat ring: grants eating so no two neighbours eat together.
// Define PHILO_STARVE_MON_EN to add per-seat starvation monitoring and neighbour blocking.
module philo_waiter
  import philo_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned AGE_W = 3,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    done,
  output logic [N-1:0]    grant,
  output logic [PtrW-1:0] rr_ptr,
  output logic [N-1:0]    starve
);

  seat_state_t     state [N];
  logic [N-1:0]    eating, waiting, sel, starve_v, blocked;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;

  for (genvar g = 0; g < N; g++) begin : g_seat
    philo_seat #(
      .AGE_W(AGE_W)
    ) u_seat (
      .clk   (clk),
      .reset (reset),
      .req   (req[g]),
      .done  (done[g]),
      .sel   (sel[g]),
      .state (state[g]),
      .starve(starve_v[g])
    );

    assign eating[g]  = (state[g] == EATING);
    assign waiting[g] = (state[g] == WAITING);
  end

`ifdef PHILO_STARVE_MON_EN
  // A starving seat reserves both of its forks by holding off its neighbours.
  always_comb begin
    blocked = '0;
    for (int unsigned i = 0; i < N; i++) begin
      blocked[i] = starve_v[left_of(i, N)] | starve_v[right_of(i, N)];
    end
  end
`else
  assign blocked = '0;
`endif

  // Seats releasing via done this cycle still count as eating, so no same-edge hand-off.
  always_comb begin
    int unsigned idx, lft, rgt, last;
    logic        any;
    sel      = '0;
    any      = 1'b0;
    idx      = 0;
    lft      = 0;
    rgt      = 0;
    last     = 0;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      lft = left_of(idx, N);
      rgt = right_of(idx, N);
      if (waiting[idx] && req[idx] && !blocked[idx] &&
          !eating[lft] && !eating[rgt] && !sel[lft] && !sel[rgt]) begin
        sel[idx] = 1'b1;
        any      = 1'b1;
        last     = idx;
      end
    end
    if (any) rr_ptr_d = PtrW'(right_of(last, N));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant  = eating;
  assign rr_ptr = rr_ptr_q;
  assign starve = starve_v;

endmodule
